alu_host_driver: RTL

- Host-side initiator for the tiny 4-bit ALU pin interface. It accepts commands (opcode, A, B) on a valid/ready port and drives the ALU's ui_in/uio pins.
- It waits a fixed settle time, samples uo_out and returns result and flags on a valid/ready response port.
- It keeps a shadow copy of the ALU register file and computes a golden result for the known opcodes. Any mismatch is flagged, so the block serves both as an on-chip self-test driver and as a reusable bench component.

---
 rtl/alu_host_driver.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_host_driver.sv
// Host-side initiator for the 4-bit ALU pin interface: drives opcode/operands,
// samples the result after a fixed settle time and checks it against a shadow model.
module alu_host_driver #(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned CNT_W         = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [3:0]       cmd_op,
   input  logic [3:0]       cmd_a,
   input  logic [3:0]       cmd_b,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [3:0]       rsp_op,
   output logic [3:0]       rsp_result,
   output logic [3:0]       rsp_flags,
   output logic             rsp_checked,
   output logic             rsp_mismatch,
   output logic [7:0]       alu_ui,
   output logic [7:0]       alu_uio,
   input  logic [7:0]       alu_uo,
   output logic             busy,
   output logic [CNT_W-1:0] cmd_count
);

   localparam int unsigned NIB_W = 4;
   localparam int unsigned REG_N = 16;
   localparam int unsigned SET_W = 4;

   localparam logic [NIB_W-1:0] OP_ADD       = 4'b0000;
   localparam logic [NIB_W-1:0] OP_PASS_B    = 4'b0111;
   localparam logic [NIB_W-1:0] OP_REG_WRITE = 4'b1000;
   localparam logic [NIB_W-1:0] OP_REG_READ  = 4'b1001;
   localparam logic [NIB_W-1:0] OP_ADD_REG   = 4'b1010;
   localparam logic [NIB_W-1:0] OP_SUB_REG   = 4'b1011;

   // The drive phase happens on the accept edge itself, so it has no state of its own.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [SET_W-1:0] settle_cnt;
   logic [NIB_W-1:0] op_q;
   logic [NIB_W-1:0] a_q;
   logic [NIB_W-1:0] b_q;
   logic [NIB_W-1:0] shadow [REG_N];
   logic [REG_N-1:0] shadow_vld;

   logic             accept_c;
   logic             sample_c;
   logic             rsp_done_c;
   logic [NIB_W-1:0] sh_val_c;
   logic             sh_vld_c;
   logic [NIB_W-1:0] gold_c;
   logic             gold_ok_c;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next state and single-cycle event strobes
   always_comb begin
      state_nxt  = state;
      accept_c   = 1'b0;
      sample_c   = 1'b0;
      rsp_done_c = 1'b0;
      case (state)
         IDLE: begin
            if (cmd_valid) begin
               accept_c  = 1'b1;
               state_nxt = SETTLE;
            end
         end
         SETTLE: begin
            if (settle_cnt == '0) begin
               sample_c  = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_done_c = 1'b1;
               state_nxt  = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Golden result from the latched command and the shadow register file
   always_comb begin
      sh_val_c  = shadow[b_q];
      sh_vld_c  = shadow_vld[b_q];
      gold_c    = '0;
      gold_ok_c = 1'b0;
      case (op_q)
         OP_ADD: begin
            gold_c    = a_q + b_q;
            gold_ok_c = 1'b1;
         end
         OP_PASS_B: begin
            gold_c    = b_q;
            gold_ok_c = 1'b1;
         end
         OP_REG_READ: begin
            gold_c    = sh_val_c;
            gold_ok_c = sh_vld_c;
         end
         OP_ADD_REG: begin
            gold_c    = a_q + sh_val_c;
            gold_ok_c = sh_vld_c;
         end
         OP_SUB_REG: begin
            gold_c    = a_q - sh_val_c;
            gold_ok_c = sh_vld_c;
         end
         default: begin
            gold_c    = '0;
            gold_ok_c = 1'b0;
         end
      endcase
   end

   // Command capture, pin drive and settle timing
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q       <= '0;
         a_q        <= '0;
         b_q        <= '0;
         alu_ui     <= '0;
         alu_uio    <= '0;
         settle_cnt <= '0;
         cmd_ready  <= 1'b1;
         busy       <= 1'b0;
      end else begin
         if (accept_c) begin
            op_q       <= cmd_op;
            a_q        <= cmd_a;
            b_q        <= cmd_b;
            alu_ui     <= {cmd_b, cmd_a};
            alu_uio    <= {4'b0000, cmd_op};
            settle_cnt <= SET_W'(SETTLE_CYCLES - 1);
            cmd_ready  <= 1'b0;
            busy       <= 1'b1;
         end else if (state == SETTLE && settle_cnt != '0) begin
            settle_cnt <= settle_cnt - SET_W'(1);
         end
         if (rsp_done_c) begin
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
         end
      end
   end

   // Response capture; fields stay frozen until the next sample
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid    <= 1'b0;
         rsp_op       <= '0;
         rsp_result   <= '0;
         rsp_flags    <= '0;
         rsp_checked  <= 1'b0;
         rsp_mismatch <= 1'b0;
         cmd_count    <= '0;
      end else begin
         if (sample_c) begin
            rsp_valid    <= 1'b1;
            rsp_op       <= op_q;
            rsp_result   <= alu_uo[3:0];
            rsp_flags    <= alu_uo[7:4];
            rsp_checked  <= gold_ok_c;
            rsp_mismatch <= gold_ok_c && (alu_uo[3:0] != gold_c);
         end
         if (rsp_done_c) begin
            rsp_valid <= 1'b0;
            cmd_count <= cmd_count + CNT_W'(1);
         end
      end
   end

   // Shadow register file, written when a REG_WRITE is accepted
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow_vld <= '0;
         for (int i = 0; i < REG_N; i++) shadow[i] <= '0;
      end else if (accept_c && cmd_op == OP_REG_WRITE) begin
         shadow[cmd_b]     <= cmd_a;
         shadow_vld[cmd_b] <= 1'b1;
      end
   end

endmodule
